// File: rtl/life_cpu_ram_bridge.sv
`default_nettype none
// ============================================================================
// life_cpu_ram_bridge : runs 1MHz-bus CPU requests on the shared SRAM in
//                       free 4-clock slots of the clk_pixel domain.
// Revision: 1.0
// ============================================================================
module life_cpu_ram_bridge #(
    parameter int                SYNC_STAGES = 2,
    parameter int                ADDR_W      = 19,
    parameter logic [ADDR_W-1:0] IDLE_ADDR   = 19'h7FFFF
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    input  logic              req_toggle,
    input  logic              req_rnw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              ack_toggle,
    output logic [7:0]        rd_data,
    input  logic              slot_free,
    input  logic [1:0]        phase,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cel,
    output logic              ram_oel,
    output logic              ram_wel,
    output logic [7:0]        ram_wdata,
    output logic              ram_drive,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          k;
    logic [1:0]          k_nxt;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                req_sync;
    logic                pending;

    logic                cap_rnw;
    logic [ADDR_W-1:0]   cap_addr;
    logic [7:0]          cap_wdata;
    logic                capture;
    logic                rd_load;

    logic                busy_nxt;
    logic                ack_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                cel_nxt;
    logic                oel_nxt;
    logic                wel_nxt;
    logic                drive_nxt;
    logic [7:0]          wdata_nxt;
    logic                write_strobe;

    assign req_sync = sync_ff[SYNC_STAGES-1];
    assign pending  = (req_sync != ack_toggle);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], req_toggle};
        end
    end

    // Next-state logic; bus outputs are computed for the cycle after the edge
    // so every pin comes straight from a flop.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        capture   = 1'b0;
        rd_load   = 1'b0;
        busy_nxt  = busy;
        ack_nxt   = ack_toggle;

        case (state)
            S_IDLE: begin
                if (pending) begin
                    capture   = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (slot_free && (phase == 2'd0)) begin
                    state_nxt = S_ACCESS;
                    k_nxt     = 2'd0;
                end
            end
            S_ACCESS: begin
                if (!slot_free) begin
                    state_nxt = S_WAIT;
                end else if (k == 2'd3) begin
                    state_nxt = S_DONE;
                    ack_nxt   = ~ack_toggle;
                    busy_nxt  = 1'b0;
                    rd_load   = cap_rnw;
                end else begin
                    k_nxt = k + 2'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        addr_nxt     = IDLE_ADDR;
        cel_nxt      = 1'b1;
        oel_nxt      = 1'b1;
        wel_nxt      = 1'b1;
        drive_nxt    = 1'b0;
        wdata_nxt    = 8'h00;
        write_strobe = (k_nxt == 2'd1) || (k_nxt == 2'd2);

        if (state_nxt == S_ACCESS) begin
            cel_nxt  = 1'b0;
            addr_nxt = cap_addr;
            if (cap_rnw) begin
                oel_nxt = 1'b0;
            end else begin
                wdata_nxt = cap_wdata;
                wel_nxt   = ~write_strobe;
                drive_nxt = write_strobe;
            end
        end
    end

    // The read sample at the edge ending k=3 lands directly in rd_data, since
    // ack_toggle flips on that same edge and both must change together.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k          <= 2'd0;
            cap_rnw    <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= 8'h00;
            busy       <= 1'b0;
            ack_toggle <= 1'b0;
            rd_data    <= 8'h00;
            ram_addr   <= IDLE_ADDR;
            ram_cel    <= 1'b1;
            ram_oel    <= 1'b1;
            ram_wel    <= 1'b1;
            ram_drive  <= 1'b0;
            ram_wdata  <= 8'h00;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            busy       <= busy_nxt;
            ack_toggle <= ack_nxt;
            ram_addr   <= addr_nxt;
            ram_cel    <= cel_nxt;
            ram_oel    <= oel_nxt;
            ram_wel    <= wel_nxt;
            ram_drive  <= drive_nxt;
            ram_wdata  <= wdata_nxt;
            if (capture) begin
                cap_rnw   <= req_rnw;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (rd_load) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/life_cpu_ram_bridge.md
Name: life_cpu_ram_bridge

Overview:
- Carries 1MHz-bus CPU read/write requests into the clk_pixel domain and performs them on the shared 512KB SRAM.
- Accesses happen only in 4-clock slots that the life/video timing leaves free.
- Sits between the 1MHz bus interface (request source) and the SRAM pin mux, beside the life engine.
- Also returns read data, so the CPU can read back the cell RAM.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on req_toggle (≥2).
- ADDR_W, 19, SRAM address width.
- IDLE_ADDR, 19'h7FFFF, address driven when the bridge is not accessing.

Ports:
- clk_pixel  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_toggle  in  1  from the clke domain. Each edge is one new request.
- req_rnw  in  1  1=read, 0=write. Stable from the req_toggle edge until ack.
- req_addr  in  ADDR_W  request address. Stable from the req_toggle edge until ack.
- req_wdata  in  8  write data. Stable from the req_toggle edge until ack.
- ack_toggle  out  1  equals req_toggle once the request has completed.
- rd_data  out  8  last read result. Valid from the ack_toggle edge.
- slot_free  in  1  high while the life engine is not using the SRAM.
- phase  in  2  h_counter[1:0]. 0 marks the start of a slot.
- ram_addr  out  ADDR_W  SRAM address.
- ram_cel  out  1  chip enable, active-low.
- ram_oel  out  1  output enable, active-low.
- ram_wel  out  1  write enable, active-low.
- ram_wdata  out  8  data to drive.
- ram_drive  out  1  pin mux drives ram_wdata while high.
- ram_rdata  in  8  SRAM data pins.
- busy  out  1  high from request detection until ack.

Behaviour:
- Reset: all outputs registered.
  - ram_cel/oel/wel = 1, ram_addr = IDLE_ADDR, ram_drive = 0, ram_wdata = 0.
  - ack_toggle = 0, rd_data = 0, busy = 0.
  - Synchroniser cleared. State = IDLE.
- Synchroniser: req_toggle passes through SYNC_STAGES flops, giving req_sync. A pending request is req_sync != ack_toggle.
- IDLE:
  - On pending: capture req_rnw, req_addr and req_wdata into local regs.
  - Set busy=1 and go to WAIT.
  - Detection latency is SYNC_STAGES+1 clocks from the req_toggle edge.
- WAIT: when slot_free=1 and phase=0, go to ACCESS with access counter k=0. Otherwise hold, bus idle.
- ACCESS, k=0..3 (phase tracks k): ram_cel=0 and ram_addr=captured address for all of k=0..3.
  - Read: ram_oel=0 for k=0..3, ram_wel=1. ram_rdata is sampled into a hold reg at the rising edge ending k=3.
  - Write: ram_oel=1. ram_wel=0 only at k=1,2. ram_drive=1 at k=1,2. ram_wdata=captured data from k=0.
  - Abort: if slot_free falls during k=0..3, release the bus next clock (idle values) and return to WAIT. The access is retried in full; a partial write is overwritten on retry.
- DONE (one clock):
  - Bus idle. rd_data updates from the hold reg on reads only; writes leave rd_data unchanged.
  - ack_toggle inverts; busy=0; go to IDLE.
  - rd_data and ack_toggle change in the same clock.
- Protocol rule: the source must not toggle req_toggle again before it sees ack_toggle match. Extra edges seen while busy are ignored until the next IDLE compare. Two toggles before detection cancel out and no access occurs.
- Bus idle values: cel/oel/wel=1, drive=0, addr=IDLE_ADDR.
- Best-case latency: detection + ≤3 clocks waiting for phase 0 + 4 access + 1 done.
- Never drive: ram_drive=1 with ram_oel=0, or ram_wel=0 with ram_cel=1.
- rst_n asserted mid-access: bus returns to idle asynchronously and the request is lost. ack_toggle=0, so the source must also reset.

Test Plan:
- Write 0xA5 to 0x12345 with slot_free=1 and phase free-running:
  - ack_toggle flips within SYNC_STAGES+9 clocks.
  - wel is low exactly 2 clocks with addr=0x12345, drive=1 and ram_wdata=0xA5.
  - oel stays 1 throughout.
- Read 0x00010 with the SRAM model returning 0x3C:
  - oel is low for 4 clocks.
  - rd_data=0x3C in the clock ack_toggle flips.
  - wel stays 1 and drive stays 0.
- Request raised while slot_free=0 for 200 clocks:
  - Bus stays idle (addr 0x7FFFF) and busy=1.
  - Access starts at the first phase=0 after slot_free rises.
- slot_free drops at k=2 of a write:
  - Next clock the bus is idle.
  - The write is repeated completely in the next slot, and the SRAM ends with the correct data.
  - Exactly one ack edge.
- Back-to-back: write 0x11 to addr 5, then read addr 5 after the ack:
  - rd_data=0x11.
  - A read of an address holding 0x00 then gives rd_data=0x00.
  - A following write leaves rd_data unchanged.
- rst_n pulsed during a read access:
  - All outputs at reset values, ack_toggle=0.
  - A fresh request after release completes normally.
